memory_access: RTL
==================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: DEPTH, 32, number of 64-bit doublewords in data memory (power of 2, 2..256).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_result  input  64  EX-stage ALU result: load/store byte address or writeback value.
REQ-005 store_data  input  64  EX-stage forwarded second ALU operand, used as store data.
REQ-006 branch_target  input  64  EX-stage computed branch address.
REQ-007 zero  input  1  EX-stage ALU zero flag.
REQ-008 write_reg  input  5  EX-stage destination register number.
REQ-009 reg_write, mem_read, mem_write, mem_to_reg, branch, uncond_branch  input  1 each  EX-stage control bits.
REQ-010 flush  input  1  replace the current EX-stage entry with a bubble.
REQ-011 ex_mem_alu_result  output  64  EX/MEM registered ALU result (feeds EX forwarding path).
REQ-012 ex_mem_write_reg  output  5; ex_mem_reg_write  output  1  EX/MEM destination info for the forwarding unit.
REQ-013 pc_src  output  1; pc_branch_target  output  64  branch-taken decision and target, from EX/MEM.
REQ-014 mem_wb_write_reg  output  5; mem_wb_reg_write  output  1  MEM/WB destination info.
REQ-015 write_back  output  64  MEM/WB writeback value (feeds register file and EX forwarding path).
REQ-016 mem_fault  output  1  sticky access-fault flag.

Function
REQ-017 EX/MEM register SHALL capture all EX-stage inputs every rising edge; with flush=1 it SHALL capture reg_write, mem_read, mem_write, branch and uncond_branch as 0 (data fields don't-care).
REQ-018 Data memory SHALL be DEPTH x 64 bits, indexed by ex_mem address bits [log2(DEPTH)+2:3].
REQ-019 An access SHALL be legal only if address[2:0]==0 and all address bits above the index are 0.
REQ-020 Store: when EX/MEM mem_write=1 and access legal, memory SHALL write the stored store_data at the rising edge that ends the MEM cycle.
REQ-021 Load: read SHALL be combinational from the EX/MEM address; MEM/WB SHALL capture the read data on the next edge; illegal loads SHALL return 64'h0.
REQ-022 Illegal stores SHALL NOT modify memory.
REQ-023 Any illegal access with mem_read or mem_write =1 SHALL set mem_fault at that edge; it SHALL stay set until reset.
REQ-024 A load in the cycle directly after a store to the same address SHALL return the new data.
REQ-025 If mem_read and mem_write are both 1, the write SHALL occur and the read data SHALL be the pre-write contents.
REQ-026 pc_src SHALL equal EX/MEM uncond_branch OR (EX/MEM branch AND EX/MEM zero), combinationally; pc_branch_target SHALL equal the EX/MEM branch_target.
REQ-027 MEM/WB register SHALL capture read data, ex_mem_alu_result, write_reg, reg_write and mem_to_reg every edge.
REQ-028 write_back SHALL equal the MEM/WB read data when MEM/WB mem_to_reg=1, else the MEM/WB ALU result, combinationally.
REQ-029 Latency: EX inputs at edge N appear on ex_mem_* after edge N; load data and write_back after edge N+1.
REQ-030 Block SHALL never stall; one entry SHALL advance per cycle.

Reset
REQ-031 While reset=1, at each edge all EX/MEM and MEM/WB fields SHALL clear to 0, mem_fault SHALL clear, and all memory words SHALL clear to 0.
REQ-032 After reset, all outputs SHALL be 0 (pc_src=0, write_back=0).
REQ-033 reset SHALL take priority over flush and any pending store; a store in EX/MEM during reset SHALL be discarded.

Verification
REQ-034 Store 64'hDEADBEEF_CAFEF00D at addr 0x10, then load addr 0x10 next cycle -> write_back=64'hDEADBEEF_CAFEF00D two edges after the load enters, mem_fault=0.
REQ-035 Load addr 0x13 (misaligned) -> write_back=0, mem_fault=1 and still 1 ten cycles later; store to 0x100 (DEPTH=32) leaves all words unchanged.
REQ-036 branch=1, zero=1, branch_target=0x40 -> pc_src=1, pc_branch_target=0x40 after one edge; same with flush=1 -> pc_src=0.
REQ-037 R-type: alu_result=7, write_reg=5, reg_write=1, mem_to_reg=0 -> ex_mem_alu_result=7 after edge N, write_back=7 and mem_wb_write_reg=5 after edge N+1.
REQ-038 Write 0xAA to addr 0x08, assert reset one cycle with a store to 0x08 in EX/MEM, then load 0x08 -> write_back=0, mem_fault=0.

Source files
------------

// File: rtl/memory_access.sv
// MEM stage of a 64-bit pipeline: EX/MEM register, DEPTH x 64 data memory, MEM/WB register, branch resolve.
// One entry advances per cycle with one edge per register; the block never stalls and has no backpressure.
module memory_access #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] alu_result,
    input  logic [63:0] store_data,
    input  logic [63:0] branch_target,
    input  logic        zero,
    input  logic [4:0]  write_reg,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        branch,
    input  logic        uncond_branch,
    input  logic        flush,
    output logic [63:0] ex_mem_alu_result,
    output logic [4:0]  ex_mem_write_reg,
    output logic        ex_mem_reg_write,
    output logic        pc_src,
    output logic [63:0] pc_branch_target,
    output logic [4:0]  mem_wb_write_reg,
    output logic        mem_wb_reg_write,
    output logic [63:0] write_back,
    output logic        mem_fault
);

    localparam int AW = $clog2(DEPTH);

    // EX/MEM pipeline register
    logic [63:0] r_em_alu;
    logic [63:0] r_em_sdata;
    logic [63:0] r_em_target;
    logic        r_em_zero;
    logic [4:0]  r_em_wr;
    logic        r_em_rw;
    logic        r_em_mr;
    logic        r_em_mw;
    logic        r_em_m2r;
    logic        r_em_br;
    logic        r_em_ub;

    // MEM/WB pipeline register
    logic [63:0] r_wb_rdata;
    logic [63:0] r_wb_alu;
    logic [4:0]  r_wb_wr;
    logic        r_wb_rw;
    logic        r_wb_m2r;

    logic [63:0] r_mem [DEPTH];
    logic        r_fault;

    logic [AW-1:0] w_index;
    logic          w_legal;
    logic [63:0]   w_rdata;
    logic          w_store;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_em_alu    <= '0;
            r_em_sdata  <= '0;
            r_em_target <= '0;
            r_em_zero   <= 1'b0;
            r_em_wr     <= '0;
            r_em_rw     <= 1'b0;
            r_em_mr     <= 1'b0;
            r_em_mw     <= 1'b0;
            r_em_m2r    <= 1'b0;
            r_em_br     <= 1'b0;
            r_em_ub     <= 1'b0;
        end else begin
            r_em_alu    <= alu_result;
            r_em_sdata  <= store_data;
            r_em_target <= branch_target;
            r_em_zero   <= zero;
            r_em_wr     <= write_reg;
            r_em_m2r    <= mem_to_reg;
            // A flushed entry keeps its data but loses every side effect
            r_em_rw     <= reg_write     & ~flush;
            r_em_mr     <= mem_read      & ~flush;
            r_em_mw     <= mem_write     & ~flush;
            r_em_br     <= branch        & ~flush;
            r_em_ub     <= uncond_branch & ~flush;
        end
    end

    always_comb begin
        w_index = r_em_alu[AW+2:3];
        w_legal = (r_em_alu[2:0] == 3'b000) && (r_em_alu[63:AW+3] == '0);
        w_rdata = w_legal ? r_mem[w_index] : 64'h0;
        w_store = r_em_mw && w_legal;
    end

    // Read is combinational on pre-edge contents, so a same-cycle read+write returns old data
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            r_mem[w_index] <= r_em_sdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if ((r_em_mr || r_em_mw) && !w_legal) begin
            r_fault <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_rdata <= '0;
            r_wb_alu   <= '0;
            r_wb_wr    <= '0;
            r_wb_rw    <= 1'b0;
            r_wb_m2r   <= 1'b0;
        end else begin
            r_wb_rdata <= w_rdata;
            r_wb_alu   <= r_em_alu;
            r_wb_wr    <= r_em_wr;
            r_wb_rw    <= r_em_rw;
            r_wb_m2r   <= r_em_m2r;
        end
    end

    always_comb begin
        ex_mem_alu_result = r_em_alu;
        ex_mem_write_reg  = r_em_wr;
        ex_mem_reg_write  = r_em_rw;
        pc_src            = r_em_ub | (r_em_br & r_em_zero);
        pc_branch_target  = r_em_target;
        mem_wb_write_reg  = r_wb_wr;
        mem_wb_reg_write  = r_wb_rw;
        write_back        = r_wb_m2r ? r_wb_rdata : r_wb_alu;
        mem_fault         = r_fault;
    end

endmodule
